entropy_shock_detector: RTL and testbench
=========================================

Name: entropy_shock_detector

Overview:
Upstream stage of the FSM entropy overlay. It consumes the raw analog entropy sample stream and maintains an exponential moving average (EMA) of it. From that it produces two things for the overlay: the shock flag, which marks a sudden drastic deviation of a sample from the average, and the 2-bit classified entropy level. Its outputs feed the overlay's shock_detected_in and classified_entropy_level inputs directly.

Parameters:
DATA_W, 8, sample and average width.
AVG_SHIFT, 3, EMA weight = 1/2^AVG_SHIFT.
SHOCK_DELTA, 64, a sample whose absolute deviation from the average is strictly greater than this is a shock.
HOLD_CYCLES, 16, minimum number of clk cycles shock_detected_out stays high after the last shock sample.
WARMUP_SAMPLES, 4, number of accepted samples before shock detection is armed.
MID_THRESH, 96, an average at or above this is classified MID.
CRIT_THRESH, 180, an average at or above this is classified CRITICAL.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
sample_valid  in  1  sample_data is valid this cycle
sample_data  in  DATA_W  raw analog entropy sample
shock_clear  in  1  forces the shock condition to end
shock_detected_out  out  1  to overlay shock_detected_in
classified_entropy_level  out  2  00 LOW, 01 MID, 10 CRITICAL; 11 is never driven
filtered_entropy  out  DATA_W  current EMA value
armed  out  1  warmup is complete
shock_count  out  8  number of shock entries, saturating

Behaviour:
- Reset values: state WARMUP; accumulator 0; hold counter 0; warmup counter 0; all outputs 0 (classified_entropy_level = LOW).
- Clock enable: nothing changes on a cycle with sample_valid=0, except the hold counter and shock_clear handling.
- EMA: accumulator is DATA_W+AVG_SHIFT bits wide.
  - Update: acc <= acc - (acc >> AVG_SHIFT) + sample.
  - filtered_entropy = acc >> AVG_SHIFT.
  - The first accepted sample after reset loads acc = sample << AVG_SHIFT.
  - No overflow is possible; the width guarantees it.
- Deviation: |sample - filtered_entropy| uses the pre-update average, computed with DATA_W+1-bit signed arithmetic.
- Latency: outputs are registered. A sample accepted at edge N is reflected in filtered_entropy, classification and shock_detected_out after edge N. There is no combinational input-to-output path.
- Classification is derived from the post-update average: avg < MID_THRESH gives LOW; avg < CRIT_THRESH gives MID; otherwise CRITICAL.
- States:
  - WARMUP: samples update the EMA and the warmup counter. Shock is never flagged. After the WARMUP_SAMPLES-th accepted sample, go to TRACK and set armed=1.
  - TRACK: if an accepted sample's deviation exceeds SHOCK_DELTA, go to SHOCK. In that case shock_detected_out=1, hold counter = HOLD_CYCLES, and shock_count increments (it saturates at 255). The EMA still updates with the shock sample.
  - SHOCK:
    - The hold counter decrements every clk cycle while nonzero.
    - Retrigger: a further shock sample reloads HOLD_CYCLES and does not increment shock_count.
    - Expiry: when the counter reaches 0, return to TRACK and drop shock_detected_out in the same edge. The flag has therefore been high for exactly HOLD_CYCLES cycles after the last shock sample.
- Simultaneous events:
  - Counter expiry and a shock sample on the same edge: the sample wins, so the block stays in SHOCK and the counter is reloaded.
  - shock_clear has priority over everything in SHOCK. It goes to TRACK, zeroes the counter and drops the flag next edge. A shock sample on the same edge is ignored for detection but still updates the EMA.
  - shock_clear in WARMUP or TRACK has no effect.
- Reset mid-operation: everything returns to the reset values and warmup restarts. The flag drops asynchronously.

Decomposition:
- Shared package: ENTROPY_LOW/MID/CRITICAL codes (the same encoding as the overlay) and the detector state enum {WARMUP, TRACK, SHOCK}.
- One natural sub-module, entropy_ema_filter, containing the accumulator, first-load logic and filtered output. The detector FSM, hold counter and classifier stay in the top.

Test Plan:
1. Reset, then valid samples 100,100,100,100 → armed=1 after the 4th; filtered_entropy=100; level MID; no shock.
2. Warmup complete at avg=50, then one sample 200 (deviation 150 > 64) → next edge shock=1, shock_count=1; shock held exactly 16 cycles, then shock=0, state TRACK.
3. Shock active with hold counter at 5, then a second 200-level sample → counter reloads to 16; shock_count stays 1; shock stays high 16 more cycles.
4. Shock active, then shock_clear=1 for one cycle together with a 250 sample → shock=0 next edge; count unchanged; EMA updated with 250.
5. Sample exactly SHOCK_DELTA away (avg 50, sample 114) → no shock. Ramp the average to ≥180 → level CRITICAL; never 11.
6. Reset asserted mid-SHOCK → shock_detected_out=0 immediately; armed=0; shock_count=0; first post-reset sample loads the average directly.

Source files
------------

// File: rtl/entropy_shock_detector_pkg.sv
// Shared encodings for the entropy shock detector: overlay level codes,
// detector state and the average-to-level classifier.
package entropy_shock_detector_pkg;

  localparam logic [1:0] ENTROPY_LOW      = 2'b00;
  localparam logic [1:0] ENTROPY_MID      = 2'b01;
  localparam logic [1:0] ENTROPY_CRITICAL = 2'b10;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    TRACK  = 2'd1,
    SHOCK  = 2'd2
  } det_state_e;

  function automatic logic [1:0] classify(input int unsigned avg,
                                          input int unsigned mid,
                                          input int unsigned crit);
    if (avg >= crit) return ENTROPY_CRITICAL;
    if (avg >= mid)  return ENTROPY_MID;
    return ENTROPY_LOW;
  endfunction

endpackage

// File: rtl/entropy_shock_detector_if.sv
// Sample stream in, shock flag / level / average out, as seen by the overlay.
interface entropy_shock_detector_if #(parameter int DATA_W = 8);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              shock_clear;
  logic              shock_detected_out;
  logic [1:0]        classified_entropy_level;
  logic [DATA_W-1:0] filtered_entropy;
  logic              armed;
  logic [7:0]        shock_count;

  modport master (
    output sample_valid, sample_data, shock_clear,
    input  shock_detected_out, classified_entropy_level, filtered_entropy, armed, shock_count
  );

  modport slave (
    input  sample_valid, sample_data, shock_clear,
    output shock_detected_out, classified_entropy_level, filtered_entropy, armed, shock_count
  );
endinterface

// File: rtl/entropy_ema_filter.sv
// EMA accumulator; the first accepted sample seeds the average directly so
// the filter does not crawl up from zero.
module entropy_ema_filter #(
  parameter int DATA_W    = 8,
  parameter int AVG_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] avg,
  output logic [DATA_W-1:0] avg_nxt
);
  localparam int ACC_W = DATA_W + AVG_SHIFT;

  logic [ACC_W-1:0] acc, acc_nxt;
  logic             loaded;

  always_comb begin
    if (loaded) acc_nxt = acc - (acc >> AVG_SHIFT) + ACC_W'(sample);
    else        acc_nxt = {sample, {AVG_SHIFT{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      loaded <= 1'b0;
    end else if (en) begin
      acc    <= acc_nxt;
      loaded <= 1'b1;
    end
  end

  assign avg     = acc[ACC_W-1:AVG_SHIFT];
  assign avg_nxt = acc_nxt[ACC_W-1:AVG_SHIFT];
endmodule

// File: rtl/entropy_shock_detector.sv
// Flags samples that jump far from the running average and classifies the
// average into the overlay's three entropy levels.
module entropy_shock_detector
  import entropy_shock_detector_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int AVG_SHIFT      = 3,
  parameter int SHOCK_DELTA    = 64,
  parameter int HOLD_CYCLES    = 16,
  parameter int WARMUP_SAMPLES = 4,
  parameter int MID_THRESH     = 96,
  parameter int CRIT_THRESH    = 180
) (
  input  logic                    clk,
  input  logic                    rst_n,
  entropy_shock_detector_if.slave bus
);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int WARM_W = $clog2(WARMUP_SAMPLES + 1);

  det_state_e        state, state_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic [WARM_W-1:0] warm, warm_nxt;
  logic [7:0]        cnt;
  logic              cnt_inc;
  logic [1:0]        lvl;
  logic [DATA_W-1:0] avg, avg_nxt;
  logic signed [DATA_W:0] diff;
  logic [DATA_W:0]   mag;
  logic              is_shock;

  entropy_ema_filter #(.DATA_W(DATA_W), .AVG_SHIFT(AVG_SHIFT)) u_ema (
    .clk(clk), .rst_n(rst_n), .en(bus.sample_valid), .sample(bus.sample_data),
    .avg(avg), .avg_nxt(avg_nxt)
  );

  // Deviation is measured against the average before this sample folds in.
  assign diff     = $signed({1'b0, bus.sample_data}) - $signed({1'b0, avg});
  assign mag      = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
  assign is_shock = bus.sample_valid && (mag > (DATA_W+1)'(SHOCK_DELTA));

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    warm_nxt  = warm;
    cnt_inc   = 1'b0;
    unique case (state)
      WARMUP: if (bus.sample_valid) begin
        warm_nxt = warm + 1'b1;
        if (warm == WARM_W'(WARMUP_SAMPLES - 1)) state_nxt = TRACK;
      end
      TRACK: if (is_shock) begin
        state_nxt = SHOCK;
        hold_nxt  = HOLD_W'(HOLD_CYCLES);
        cnt_inc   = 1'b1;
      end
      SHOCK: begin
        // Clear beats a retrigger, which beats expiry.
        if (bus.shock_clear) begin
          state_nxt = TRACK;
          hold_nxt  = '0;
        end else if (is_shock) begin
          hold_nxt  = HOLD_W'(HOLD_CYCLES);
        end else if (hold <= HOLD_W'(1)) begin
          state_nxt = TRACK;
          hold_nxt  = '0;
        end else begin
          hold_nxt  = hold - 1'b1;
        end
      end
      default: begin
        state_nxt = WARMUP;
        hold_nxt  = '0;
        warm_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WARMUP;
      hold  <= '0;
      warm  <= '0;
      cnt   <= '0;
      lvl   <= ENTROPY_LOW;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      warm  <= warm_nxt;
      if (cnt_inc && cnt != 8'hFF) cnt <= cnt + 8'd1;
      if (bus.sample_valid)
        lvl <= classify(32'(avg_nxt), 32'(MID_THRESH), 32'(CRIT_THRESH));
    end
  end

  assign bus.shock_detected_out       = (state == SHOCK);
  assign bus.armed                    = (state != WARMUP);
  assign bus.classified_entropy_level = lvl;
  assign bus.filtered_entropy         = avg;
  assign bus.shock_count              = cnt;
endmodule

// File: tb/tb_entropy_shock_detector.sv
// Bench for entropy_shock_detector: vector table, corner-case sequences and
// randomized traffic against an integer reference model.
module tb_entropy_shock_detector;
  import entropy_shock_detector_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  entropy_shock_detector_if #(.DATA_W(8)) bus ();
  entropy_shock_detector dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: running average as an integer, shock as a countdown.
  int m_acc, m_warm, m_hold, m_cnt;
  bit m_loaded;

  function automatic logic [1:0] m_lvl(input int a);
    if (a >= 180) return 2'b10;
    if (a >= 96)  return 2'b01;
    return 2'b00;
  endfunction

  task automatic m_reset();
    m_acc = 0; m_warm = 0; m_hold = 0; m_cnt = 0; m_loaded = 0;
  endtask

  task automatic m_step(input bit v, input int d, input bit clr);
    int pre, dev;
    bit sh;
    pre = m_acc / 8;
    dev = d - pre;
    if (dev < 0) dev = -dev;
    sh = v && (m_warm >= 4) && (dev > 64);
    if (m_hold > 0) begin
      if (clr)     m_hold = 0;
      else if (sh) m_hold = 16;
      else         m_hold = m_hold - 1;
    end else if (sh) begin
      m_hold = 16;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end
    if (v) begin
      m_acc = m_loaded ? (m_acc - m_acc / 8 + d) : d * 8;
      m_loaded = 1;
      if (m_warm < 4) m_warm = m_warm + 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("shock", 32'(bus.shock_detected_out), 32'(m_hold > 0));
    chk("level", 32'(bus.classified_entropy_level), 32'(m_lvl(m_acc / 8)));
    chk("filtered", 32'(bus.filtered_entropy), 32'(m_acc / 8));
    chk("armed", 32'(bus.armed), 32'(m_warm >= 4));
    chk("count", 32'(bus.shock_count), 32'(m_cnt));
    chk("level_legal", 32'(bus.classified_entropy_level == 2'b11), 32'd0);
  endtask

  // Inputs are applied 1 time unit after an edge and outputs sampled 1 unit
  // after the next edge.
  task automatic step(input bit v, input int d, input bit clr);
    bus.sample_valid = v;
    bus.sample_data  = 8'(d);
    bus.shock_clear  = clr;
    @(posedge clk);
    m_step(v, d, clr);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.shock_clear  = 1'b0;
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit rst; bit v; int d; bit clr;
    bit e_shock; int e_lvl; int e_filt; bit e_arm; int e_cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int d, pre, r;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.shock_clear  = 1'b0;
    m_reset();

    tbl[0]  = '{1, 0,   0, 0,  0, 0,   0, 0, 0};
    tbl[1]  = '{0, 1, 100, 0,  0, 1, 100, 0, 0};
    tbl[2]  = '{0, 1, 100, 0,  0, 1, 100, 0, 0};
    tbl[3]  = '{0, 1, 100, 0,  0, 1, 100, 0, 0};
    tbl[4]  = '{0, 1, 100, 0,  0, 1, 100, 1, 0};
    tbl[5]  = '{1, 0,   0, 0,  0, 0,   0, 0, 0};
    tbl[6]  = '{0, 1,  50, 0,  0, 0,  50, 0, 0};
    tbl[7]  = '{0, 1,  50, 0,  0, 0,  50, 0, 0};
    tbl[8]  = '{0, 1,  50, 1,  0, 0,  50, 0, 0};
    tbl[9]  = '{0, 1,  50, 0,  0, 0,  50, 1, 0};
    tbl[10] = '{0, 1, 114, 0,  0, 0,  58, 1, 0};
    tbl[11] = '{0, 1, 200, 0,  1, 0,  75, 1, 1};

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) do_reset();
      else            step(tbl[i].v, tbl[i].d, tbl[i].clr);
      chk("tbl_shock", 32'(bus.shock_detected_out), 32'(tbl[i].e_shock));
      chk("tbl_level", 32'(bus.classified_entropy_level), 32'(tbl[i].e_lvl));
      chk("tbl_filt", 32'(bus.filtered_entropy), 32'(tbl[i].e_filt));
      chk("tbl_armed", 32'(bus.armed), 32'(tbl[i].e_arm));
      chk("tbl_count", 32'(bus.shock_count), 32'(tbl[i].e_cnt));
    end

    // Flag lasts exactly 16 cycles after the last shock sample.
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0);
      chk("hold_len", 32'(bus.shock_detected_out), 32'(i < 16));
    end

    // Retrigger with the counter at 5: reload, no extra count.
    step(1, 200, 0);
    chk("shock2_count", 32'(bus.shock_count), 32'd2);
    for (int i = 0; i < 11; i++) step(0, 0, 0);
    chk("pre_retrig", 32'(bus.shock_detected_out), 32'd1);
    step(1, 200, 0);
    chk("retrig_count", 32'(bus.shock_count), 32'd2);
    chk("retrig_filt", 32'(bus.filtered_entropy), 32'd105);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0);
      chk("retrig_hold", 32'(bus.shock_detected_out), 32'(i < 16));
    end

    // Clear together with a shock-sized sample.
    step(1, 250, 0);
    chk("shock3", 32'(bus.shock_detected_out), 32'd1);
    step(1, 250, 1);
    chk("clear_shock", 32'(bus.shock_detected_out), 32'd0);
    chk("clear_count", 32'(bus.shock_count), 32'd3);
    chk("clear_filt", 32'(bus.filtered_entropy), 32'd139);

    // Ramp the average into CRITICAL.
    for (int i = 0; i < 30; i++) step(1, 250, 0);
    chk("crit_level", 32'(bus.classified_entropy_level), 32'(ENTROPY_CRITICAL));

    // Asynchronous reset in the middle of a shock.
    step(1, 0, 0);
    step(0, 0, 0);
    chk("pre_rst_shock", 32'(bus.shock_detected_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_shock", 32'(bus.shock_detected_out), 32'd0);
    chk("async_armed", 32'(bus.armed), 32'd0);
    chk("async_count", 32'(bus.shock_count), 32'd0);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 77, 0);
    chk("reload_filt", 32'(bus.filtered_entropy), 32'd77);

    // Randomized traffic, biased toward the +/-64 deviation boundary.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      pre = m_acc / 8;
      case ($urandom_range(0, 3))
        0: d = int'($urandom_range(0, 255));
        1: d = pre + 64 + int'($urandom_range(0, 1));
        2: d = pre - 64 - int'($urandom_range(0, 1));
        default: d = pre + int'($urandom_range(0, 60)) - 30;
      endcase
      if (d < 0) d = 0;
      if (d > 255) d = 255;
      if (r == 0) begin
        do_reset();
        check_model();
      end else begin
        step($urandom_range(0, 9) < 7, d, $urandom_range(0, 19) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
